// File: rtl/blinker_pkg.sv
// Shared definitions for the event blinker: state encoding and timer sizing.
package blinker_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ON   = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_ON   = ON,
      ST_GAP  = GAP
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Never returns zero so that ON_CYCLES = OFF_CYCLES = 1 still yields a legal vector.
   function automatic int timer_width(input int a, input int b);
      int w;
      w = clog2((a > b) ? a : b);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter that parks at zero; done flags the terminal count.
module interval_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         ena,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (ena && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event strobes into fixed-length LED blinks separated by a dark gap,
// queueing strobes that arrive mid-blink in a saturating counter.
module event_blinker
   import blinker_pkg::*;
#(
   parameter int ON_CYCLES  = 2400000,
   parameter int OFF_CYCLES = 1200000,
   parameter int PEND_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evt_in,
   input  logic              clr_ovf,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
   localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t            state_reg, state_next;
   logic              led_reg;
   logic [PEND_W-1:0] pend_reg, pend_next;
   logic              ovf_reg, ovf_next;

   logic              start;
   logic              go_on;
   logic              consume;
   logic              accept;
   logic              ovf_set;
   logic              t_load;
   logic [TW-1:0]     t_val;
   logic              t_ena;
   logic              t_done;

   interval_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .ena      (t_ena),
      .done     (t_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         led_reg   <= 1'b0;
         pend_reg  <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         led_reg   <= (state_next == ST_ON);
         pend_reg  <= pend_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      t_load     = 1'b0;
      t_val      = ON_LOAD;
      t_ena      = 1'b0;
      start      = (pend_reg != '0) || evt_in;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_ON;
               t_load     = 1'b1;
               t_val      = ON_LOAD;
            end
         end
         ST_ON: begin
            if (t_done) begin
               state_next = ST_GAP;
               t_load     = 1'b1;
               t_val      = OFF_LOAD;
            end else begin
               t_ena = 1'b1;
            end
         end
         ST_GAP: begin
            if (t_done) begin
               if (start) begin
                  state_next = ST_ON;
                  t_load     = 1'b1;
                  t_val      = ON_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               t_ena = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A blink started with an empty queue is fed by evt_in itself, so that event is not counted.
   always_comb begin
      go_on     = (state_next == ST_ON) && (state_reg != ST_ON);
      consume   = go_on && (pend_reg != '0);
      accept    = evt_in && !(go_on && (pend_reg == '0));
      pend_next = pend_reg;
      ovf_set   = 1'b0;
      if (accept && !consume) begin
         if (pend_reg == PEND_MAX) begin
            ovf_set = 1'b1;
         end else begin
            pend_next = pend_reg + PEND_W'(1);
         end
      end else if (consume && !accept) begin
         pend_next = pend_reg - PEND_W'(1);
      end
      ovf_next = ovf_set || (ovf_reg && !clr_ovf);
   end

   assign led_out  = led_reg;
   assign busy     = (state_reg != ST_IDLE);
   assign pending  = pend_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with ON=3, OFF=2, PEND_W=2; cycle numbers follow the test plan.
module tb_event_blinker;

   logic       clk;
   logic       rst;
   logic       evt_in;
   logic       clr_ovf;
   logic       led_out;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   int total;
   int bad;

   event_blinker #(
      .ON_CYCLES  (3),
      .OFF_CYCLES (2),
      .PEND_W     (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .evt_in   (evt_in),
      .clr_ovf  (clr_ovf),
      .led_out  (led_out),
      .busy     (busy),
      .pending  (pending),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs for one cycle, then sample registered outputs at the falling edge.
   task automatic step(input logic e, input logic c);
      @(posedge clk);
      #1;
      evt_in  = e;
      clr_ovf = c;
      @(negedge clk);
   endtask

   task automatic do_reset();
      evt_in  = 1'b0;
      clr_ovf = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Pending depth for a burst of events at cycles 10..13 (or 10..14 with the last dropped).
   function automatic int burst_pend(input int c);
      if (c == 12) return 1;
      if (c == 13) return 2;
      if (c == 14 || c == 15) return 3;
      if (c >= 16 && c <= 20) return 2;
      if (c >= 21 && c <= 25) return 1;
      return 0;
   endfunction

   task automatic test_reset();
      rst     = 1'b1;
      evt_in  = 1'b0;
      clr_ovf = 1'b0;
      #2;
      total += 4;
      if (led_out !== 1'b0) begin bad++; $display("FAIL reset led got=%b want=0", led_out); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
      if (pending !== 2'd0) begin bad++; $display("FAIL reset pending got=%0d want=0", pending); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow got=%b want=0", overflow); end
      $display("reset: led=%b busy=%b pending=%0d overflow=%b", led_out, busy, pending, overflow);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      logic [63:0] led_e;
      logic [63:0] busy_e;
      led_e  = 64'h3800;
      busy_e = 64'hF800;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         step(c == 10, 1'b0);
         total += 3;
         if (led_out !== led_e[c]) begin bad++; $display("FAIL single led c=%0d got=%b want=%b", c, led_out, led_e[c]); end
         if (busy !== busy_e[c]) begin bad++; $display("FAIL single busy c=%0d got=%b want=%b", c, busy, busy_e[c]); end
         if (pending !== 2'd0) begin bad++; $display("FAIL single pending c=%0d got=%0d want=0", c, pending); end
      end
      $display("single: done, led=%b busy=%b", led_out, busy);
   endtask

   task automatic test_queue();
      logic [63:0] led_e;
      logic [63:0] busy_e;
      led_e  = 64'h1CE7_3800;
      busy_e = 64'h7FFF_F800;
      do_reset();
      for (int c = 0; c < 34; c++) begin
         step(c >= 10 && c <= 13, 1'b0);
         total += 4;
         if (led_out !== led_e[c]) begin bad++; $display("FAIL queue led c=%0d got=%b want=%b", c, led_out, led_e[c]); end
         if (busy !== busy_e[c]) begin bad++; $display("FAIL queue busy c=%0d got=%b want=%b", c, busy, busy_e[c]); end
         if (int'(pending) != burst_pend(c)) begin bad++; $display("FAIL queue pending c=%0d got=%0d want=%0d", c, pending, burst_pend(c)); end
         if (overflow !== 1'b0) begin bad++; $display("FAIL queue overflow c=%0d got=%b want=0", c, overflow); end
      end
      $display("queue: four blinks checked, pending=%0d", pending);
   endtask

   task automatic test_overflow();
      logic [63:0] led_e;
      logic [63:0] busy_e;
      logic        ovf_e;
      led_e  = 64'h1CE7_3800;
      busy_e = 64'h7FFF_F800;
      do_reset();
      for (int c = 0; c < 45; c++) begin
         step(c >= 10 && c <= 14, c == 40);
         ovf_e = (c >= 15 && c <= 40);
         total += 4;
         if (led_out !== led_e[c]) begin bad++; $display("FAIL ovf led c=%0d got=%b want=%b", c, led_out, led_e[c]); end
         if (busy !== busy_e[c]) begin bad++; $display("FAIL ovf busy c=%0d got=%b want=%b", c, busy, busy_e[c]); end
         if (int'(pending) != burst_pend(c)) begin bad++; $display("FAIL ovf pending c=%0d got=%0d want=%0d", c, pending, burst_pend(c)); end
         if (overflow !== ovf_e) begin bad++; $display("FAIL ovf flag c=%0d got=%b want=%b", c, overflow, ovf_e); end
      end
      $display("overflow: drop, sticky flag and clear checked, overflow=%b", overflow);
   endtask

   task automatic test_back_to_back();
      logic [63:0] led_e;
      logic [63:0] busy_e;
      led_e  = 64'h7_3800;
      busy_e = 64'h1F_F800;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         step(c == 10 || c == 15, 1'b0);
         total += 3;
         if (led_out !== led_e[c]) begin bad++; $display("FAIL b2b led c=%0d got=%b want=%b", c, led_out, led_e[c]); end
         if (busy !== busy_e[c]) begin bad++; $display("FAIL b2b busy c=%0d got=%b want=%b", c, busy, busy_e[c]); end
         if (pending !== 2'd0) begin bad++; $display("FAIL b2b pending c=%0d got=%0d want=0", c, pending); end
      end
      $display("back_to_back: gap-end restart checked");
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int c = 0; c < 18; c++) step(c >= 10 && c <= 14, 1'b0);
      total += 3;
      if (led_out !== 1'b1) begin bad++; $display("FAIL arst pre led got=%b want=1", led_out); end
      if (pending !== 2'd2) begin bad++; $display("FAIL arst pre pending got=%0d want=2", pending); end
      if (overflow !== 1'b1) begin bad++; $display("FAIL arst pre overflow got=%b want=1", overflow); end
      #1 rst = 1'b1;
      #1;
      total += 4;
      if (led_out !== 1'b0) begin bad++; $display("FAIL arst led got=%b want=0", led_out); end
      if (busy !== 1'b0) begin bad++; $display("FAIL arst busy got=%b want=0", busy); end
      if (pending !== 2'd0) begin bad++; $display("FAIL arst pending got=%0d want=0", pending); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL arst overflow got=%b want=0", overflow); end
      @(posedge clk);
      #1 rst = 1'b0;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      total += 1;
      if (led_out !== 1'b0) begin bad++; $display("FAIL arst evt-cycle led got=%b want=0", led_out); end
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, 1'b0);
         total += 3;
         if (led_out !== (k <= 3)) begin bad++; $display("FAIL arst blink led k=%0d got=%b want=%b", k, led_out, (k <= 3)); end
         if (busy !== (k <= 5)) begin bad++; $display("FAIL arst blink busy k=%0d got=%b want=%b", k, busy, (k <= 5)); end
         if (pending !== 2'd0) begin bad++; $display("FAIL arst blink pending k=%0d got=%0d want=0", k, pending); end
      end
      $display("async_reset: immediate clear and fresh blink checked");
   endtask

   task automatic test_clr_vs_set();
      int   pend_e;
      logic ovf_e;
      do_reset();
      for (int c = 0; c < 23; c++) begin
         step(c >= 10 && c <= 16, c == 16 || c == 21);
         if (c == 12) pend_e = 1;
         else if (c == 13) pend_e = 2;
         else if (c >= 14 && c <= 20) pend_e = 3;
         else if (c >= 21) pend_e = 2;
         else pend_e = 0;
         ovf_e = (c >= 15 && c <= 21);
         total += 2;
         if (int'(pending) != pend_e) begin bad++; $display("FAIL clrset pending c=%0d got=%0d want=%0d", c, pending, pend_e); end
         if (overflow !== ovf_e) begin bad++; $display("FAIL clrset overflow c=%0d got=%b want=%b", c, overflow, ovf_e); end
      end
      $display("clr_vs_set: set wins over clear, plain clear checked");
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b0;
      evt_in  = 1'b0;
      clr_ovf = 1'b0;
      test_reset();
      test_single();
      test_queue();
      test_overflow();
      test_back_to_back();
      test_async_reset();
      test_clr_vs_set();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/event_blinker.md
Name: event_blinker

Overview:
- Output-side counterpart to the switch debouncer. The debouncer turns a slow, noisy human input into clean single-cycle events; this block turns single-cycle events into human-visible LED blinks.
- Every input strobe produces exactly one LED pulse of fixed length, followed by a fixed dark gap.
- Strobes that arrive while a blink is in progress are queued in a saturating counter, so no click is lost until the queue is full.
- Sits between event sources (debounced clicks, counter wrap) and a board LED pin.

Parameters:
ON_CYCLES, 2400000, LED-on duration in clk cycles (200 ms at 12 MHz); must be >= 1
OFF_CYCLES, 1200000, dark gap after each blink in clk cycles; must be >= 1
PEND_W, 4, width of pending-event counter; queue depth = 2^PEND_W - 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
evt_in  in  1  event strobe; each high cycle is one event; synchronous to clk
clr_ovf  in  1  clears overflow flag (synchronous)
led_out  out  1  registered LED drive; 1 = on
busy  out  1  1 when state != IDLE
pending  out  PEND_W  queued events not yet started
overflow  out  1  sticky: an event was dropped because the queue was full

Behaviour:
- Reset (async, immediate): state=IDLE, led_out=0, busy=0, pending=0, overflow=0, timer=0. Reset mid-blink drops led_out to 0 at once and discards the queue.
- FSM states: IDLE, ON, GAP. led_out = (state==ON), taken from a register, no combinational path from evt_in. busy = (state!=IDLE).
- start condition = (pending!=0) || evt_in.
- IDLE: if start, go to ON and load timer with ON_CYCLES-1; otherwise stay.
- ON: timer decrements each cycle; at timer==0, go to GAP and load OFF_CYCLES-1. ON lasts exactly ON_CYCLES cycles.
- GAP: timer decrements; at timer==0, if start go directly to ON (no IDLE cycle), else go to IDLE. GAP lasts exactly OFF_CYCLES cycles.
- Latency: evt_in high in cycle t while in IDLE with pending=0 -> led_out high in cycles t+1 .. t+ON_CYCLES.
- Back-to-back blinks repeat with a period of ON_CYCLES+OFF_CYCLES.
- consume = transition into ON while pending!=0. A start fed only by evt_in with pending==0 does not touch pending.
- Pending update per edge:
  - evt_in and not consume -> +1
  - consume and not evt_in -> -1
  - both or neither -> unchanged
  - exception: an evt_in at IDLE/GAP-end with pending==0 starts the blink directly and does not count.
- Saturation: pending==2^PEND_W-1, evt_in=1, no consume -> event dropped, pending unchanged, overflow<=1. Event plus consume at max -> pending unchanged, no overflow.
- overflow is sticky until clr_ovf. If clr_ovf and a new overflow occur in the same cycle, set wins.
- Timer width = $clog2(max(ON_CYCLES,OFF_CYCLES)). No wrap-around; the timer is always reloaded before it is used.

Decomposition:
- Package blinker_pkg: state encoding localparams (IDLE=0, ON=1, GAP=2) and a clog2 helper function for timer width.
- One sub-module, interval_timer: loadable down-counter (load, load_val, ena, done when count==0), parameter W. Reusable by the debouncer.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2, PEND_W=2; cycle numbers are the cycle evt_in is high):
- Single evt at cycle 10 -> led_out=1 in cycles 11-13, 0 from 14; busy=1 in 11-15, 0 at 16; pending stays 0.
- evt at cycles 10,11,12,13 -> pending 1,2,3 after 11,12,13; four blinks starting at cycles 11,16,21,26, each 3 on / 2 off; overflow stays 0.
- evt at cycles 10-14 -> 5th event dropped (pending=3, no consume at 14); overflow=1 from cycle 15; exactly four blinks; clr_ovf at 40 -> overflow=0 at 41.
- Single evt at 10, second evt at 15 (last GAP cycle) -> second blink starts at cycle 16 with no IDLE cycle; pending never leaves 0.
- Queue 3 events, assert rst asynchronously mid-ON -> led_out=0, pending=0, overflow=0 immediately. Release rst, evt 2 cycles later -> fresh 3-cycle blink.
- With overflow=1 and pending=3, pulse clr_ovf and an overflowing evt_in in the same cycle -> overflow remains 1.
